// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_control_unit_if : decode/branch inputs and stall/flush/forward outputs
//                          of the pipeline hazard controller.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface hazard_control_unit_if #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 3,
  parameter int CNT_W      = 16
);
  logic                          halt;
  logic                          deco_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] deco_src_addr;
  logic [NUM_SRC-1:0]            deco_src_used;
  logic [REG_ADDR_W-1:0]         deco_dst_addr;
  logic                          deco_reg_write;
  logic                          deco_mem_to_reg;
  logic                          branch_taken_exe;

  logic                          stall_fetch;
  logic                          stall_deco;
  logic                          flush_if_de;
  logic                          flush_deco_exe;
  logic [2*NUM_SRC-1:0]          forward_sel;
  logic [CNT_W-1:0]              stall_count;
  logic [CNT_W-1:0]              flush_count;

  modport master (
    output halt, deco_valid, deco_src_addr, deco_src_used, deco_dst_addr,
           deco_reg_write, deco_mem_to_reg, branch_taken_exe,
    input  stall_fetch, stall_deco, flush_if_de, flush_deco_exe, forward_sel,
           stall_count, flush_count
  );

  modport slave (
    input  halt, deco_valid, deco_src_addr, deco_src_used, deco_dst_addr,
           deco_reg_write, deco_mem_to_reg, branch_taken_exe,
    output stall_fetch, stall_deco, flush_if_de, flush_deco_exe, forward_sel,
           stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_control_unit : shadow EXE/MEM/WB tag pipeline driving forwarding
//                       selects, load-use stall, branch flush and halt freeze.
// Revision : 1.0
// ----------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 3,
  parameter int PC_REG     = 15,
  parameter int CNT_W      = 16
) (
  input  wire logic            clk,
  input  wire logic            reset,
  hazard_control_unit_if.slave bus
);

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);
  localparam logic [CNT_W-1:0]      CNT_MAX = '1;

  logic                          exe_valid_q, exe_valid_d;
  logic                          exe_rw_q,    exe_rw_d;
  logic                          exe_load_q,  exe_load_d;
  logic [REG_ADDR_W-1:0]         exe_dst_q,   exe_dst_d;
  logic [NUM_SRC*REG_ADDR_W-1:0] exe_src_q,   exe_src_d;
  logic [NUM_SRC-1:0]            exe_used_q,  exe_used_d;
  logic                          mem_valid_q, mem_valid_d;
  logic                          mem_rw_q,    mem_rw_d;
  logic                          mem_load_q,  mem_load_d;
  logic [REG_ADDR_W-1:0]         mem_dst_q,   mem_dst_d;
  logic                          wb_valid_q,  wb_valid_d;
  logic                          wb_rw_q,     wb_rw_d;
  logic [REG_ADDR_W-1:0]         wb_dst_q,    wb_dst_d;
  logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]              flush_cnt_q, flush_cnt_d;

  logic                          load_use;
  logic                          stall;
  logic                          flush_if;
  logic                          flush_de;
  logic [2*NUM_SRC-1:0]          fwd;

  // The PC register is written by every branch but never forwarded or stalled on.
  function automatic logic hit(input logic v, input logic rw,
                               input logic [REG_ADDR_W-1:0] dst,
                               input logic [REG_ADDR_W-1:0] s);
    return v && rw && (dst == s) && (s != PC_ADDR);
  endfunction

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.deco_src_used[i] &&
          hit(exe_valid_q, exe_rw_q, exe_dst_q, bus.deco_src_addr[i*REG_ADDR_W +: REG_ADDR_W]))
        load_use = 1'b1;
    end
    load_use = load_use && bus.deco_valid && exe_load_q;
  end

  always_comb begin
    stall    = 1'b0;
    flush_if = 1'b0;
    flush_de = 1'b0;
    if (bus.halt) begin
      stall = 1'b1;
    end else if (bus.branch_taken_exe) begin
      flush_if = 1'b1;
      flush_de = 1'b1;
    end else if (load_use) begin
      stall    = 1'b1;
      flush_de = 1'b1;
    end
  end

  always_comb begin
    exe_valid_d = exe_valid_q;
    exe_rw_d    = exe_rw_q;
    exe_load_d  = exe_load_q;
    exe_dst_d   = exe_dst_q;
    exe_src_d   = exe_src_q;
    exe_used_d  = exe_used_q;
    mem_valid_d = mem_valid_q;
    mem_rw_d    = mem_rw_q;
    mem_load_d  = mem_load_q;
    mem_dst_d   = mem_dst_q;
    wb_valid_d  = wb_valid_q;
    wb_rw_d     = wb_rw_q;
    wb_dst_d    = wb_dst_q;
    if (!bus.halt) begin
      wb_valid_d  = mem_valid_q;
      wb_rw_d     = mem_rw_q;
      wb_dst_d    = mem_dst_q;
      mem_valid_d = exe_valid_q;
      mem_rw_d    = exe_rw_q;
      mem_load_d  = exe_load_q;
      mem_dst_d   = exe_dst_q;
      if (flush_de) begin
        exe_valid_d = 1'b0;
        exe_rw_d    = 1'b0;
        exe_load_d  = 1'b0;
        exe_dst_d   = '0;
        exe_src_d   = '0;
        exe_used_d  = '0;
      end else begin
        exe_valid_d = bus.deco_valid;
        exe_rw_d    = bus.deco_reg_write;
        exe_load_d  = bus.deco_mem_to_reg;
        exe_dst_d   = bus.deco_dst_addr;
        exe_src_d   = bus.deco_src_addr;
        exe_used_d  = bus.deco_src_used;
      end
    end
  end

  // A flush outranks a load-use, so a stall is only counted without a flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_if && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (flush_de && !flush_if && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_valid_q <= 1'b0;
      exe_rw_q    <= 1'b0;
      exe_load_q  <= 1'b0;
      exe_dst_q   <= '0;
      exe_src_q   <= '0;
      exe_used_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_load_q  <= 1'b0;
      mem_dst_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_dst_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      exe_valid_q <= exe_valid_d;
      exe_rw_q    <= exe_rw_d;
      exe_load_q  <= exe_load_d;
      exe_dst_q   <= exe_dst_d;
      exe_src_q   <= exe_src_d;
      exe_used_q  <= exe_used_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_load_q  <= mem_load_d;
      mem_dst_q   <= mem_dst_d;
      wb_valid_q  <= wb_valid_d;
      wb_rw_q     <= wb_rw_d;
      wb_dst_q    <= wb_dst_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // MEM holds the newest result; a load still in MEM has no data yet and is never selected.
  always_comb begin
    fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (exe_valid_q && exe_used_q[i]) begin
        if (hit(mem_valid_q, mem_rw_q, mem_dst_q, exe_src_q[i*REG_ADDR_W +: REG_ADDR_W]) && !mem_load_q)
          fwd[2*i +: 2] = 2'b01;
        else if (hit(wb_valid_q, wb_rw_q, wb_dst_q, exe_src_q[i*REG_ADDR_W +: REG_ADDR_W]))
          fwd[2*i +: 2] = 2'b10;
      end
    end
  end

  assign bus.stall_fetch    = !reset && stall;
  assign bus.stall_deco     = !reset && stall;
  assign bus.flush_if_de    = !reset && flush_if;
  assign bus.flush_deco_exe = !reset && flush_de;
  assign bus.forward_sel    = reset ? '0 : fwd;
  assign bus.stall_count    = reset ? '0 : stall_cnt_q;
  assign bus.flush_count    = reset ? '0 : flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hazard_control_unit : directed scenarios plus randomized traffic checked
//                          against a struct-based pipeline reference model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_hazard_control_unit;
  localparam int W    = 4;
  localparam int N    = 3;
  localparam int PC   = 15;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.REG_ADDR_W(W), .NUM_SRC(N), .CNT_W(CW)) bus();

  hazard_control_unit #(.REG_ADDR_W(W), .NUM_SRC(N), .PC_REG(PC), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic                v;
    logic                rw;
    logic                ld;
    logic [W-1:0]        dst;
    logic [N-1:0][W-1:0] src;
    logic [N-1:0]        used;
  } ent_t;

  ent_t m_exe, m_mem, m_wb;
  int   m_stalls, m_flushes;
  int   checks = 0;
  int   errors = 0;

  function automatic bit mmatch(ent_t e, logic [W-1:0] s);
    return e.v && e.rw && (e.dst == s) && (s != PC);
  endfunction

  function automatic bit exp_lu();
    bit r = 0;
    for (int i = 0; i < N; i++)
      if (bus.deco_src_used[i] && mmatch(m_exe, bus.deco_src_addr[i*W +: W])) r = 1;
    return r && bus.deco_valid && m_exe.ld;
  endfunction

  // {stall_fetch, stall_deco, flush_if_de, flush_deco_exe}
  function automatic logic [3:0] exp_ctl();
    if (reset)                return 4'b0000;
    if (bus.halt)             return 4'b1100;
    if (bus.branch_taken_exe) return 4'b0011;
    if (exp_lu())             return 4'b1101;
    return 4'b0000;
  endfunction

  function automatic logic [2*N-1:0] exp_fwd();
    logic [2*N-1:0] f = '0;
    if (reset) return '0;
    for (int i = 0; i < N; i++) begin
      if (m_exe.v && m_exe.used[i]) begin
        if (mmatch(m_mem, m_exe.src[i]) && !m_mem.ld) f[2*i +: 2] = 2'b01;
        else if (mmatch(m_wb, m_exe.src[i]))          f[2*i +: 2] = 2'b10;
      end
    end
    return f;
  endfunction

  function automatic logic [3:0] obs_ctl();
    return {bus.stall_fetch, bus.stall_deco, bus.flush_if_de, bus.flush_deco_exe};
  endfunction

  task automatic clear_model();
    m_exe = '0; m_mem = '0; m_wb = '0;
    m_stalls = 0; m_flushes = 0;
  endtask

  task automatic instr(input bit v, input bit rw, input bit ld, input logic [W-1:0] dst,
                       input logic [W-1:0] s0, input logic [W-1:0] s1, input logic [W-1:0] s2,
                       input logic [N-1:0] used);
    bus.deco_valid      = v;
    bus.deco_reg_write  = rw;
    bus.deco_mem_to_reg = ld;
    bus.deco_dst_addr   = dst;
    bus.deco_src_addr   = {s2, s1, s0};
    bus.deco_src_used   = used;
  endtask

  task automatic nop();
    instr(0, 0, 0, 0, 0, 0, 0, 3'b000);
  endtask

  // Advances one clock; the model consumes the inputs that were present at the edge.
  task automatic tick();
    bit h, br, lu;
    ent_t d;
    h  = bus.halt;
    br = bus.branch_taken_exe;
    lu = exp_lu();
    d  = '{v: bus.deco_valid, rw: bus.deco_reg_write, ld: bus.deco_mem_to_reg,
           dst: bus.deco_dst_addr, src: bus.deco_src_addr, used: bus.deco_src_used};
    @(posedge clk);
    if (reset) begin
      clear_model();
    end else if (!h) begin
      m_wb  = m_mem;
      m_mem = m_exe;
      if (br) begin
        m_exe = '0;
        m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
      end else if (lu) begin
        m_exe = '0;
        m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
      end else begin
        m_exe = d;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    bus.halt = 0; bus.branch_taken_exe = 0; nop();
    reset = 1'b1;
    clear_model();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.halt = 1; bus.branch_taken_exe = 1;
    instr(1, 1, 1, 4'd2, 4'd2, 4'd2, 4'd2, 3'b111);
    #1 reset = 1'b1;
    clear_model();
    #2;
    checks++; if (obs_ctl() !== 4'b0000) begin errors++; $display("FAIL reset_ctl got=%b exp=0000", obs_ctl()); end
    checks++; if (bus.forward_sel !== 6'b0) begin errors++; $display("FAIL reset_fwd got=%b exp=000000", bus.forward_sel); end
    checks++; if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_count, bus.flush_count); end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.halt = 0; bus.branch_taken_exe = 0; nop();
    #1;
    checks++; if (bus.stall_count !== 4'd0 || bus.forward_sel !== 6'b0) begin
      errors++; $display("FAIL reset_release got=%0d/%b exp=0/000000", bus.stall_count, bus.forward_sel); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    instr(1, 1, 0, 4'd1, 4'd2, 4'd3, 4'd0, 3'b011);
    tick();
    instr(1, 1, 0, 4'd4, 4'd1, 4'd1, 4'd0, 3'b011);
    #1;
    checks++; if (obs_ctl() !== 4'b0000) begin errors++; $display("FAIL b2b_nostall got=%b exp=0000", obs_ctl()); end
    tick();
    nop(); #1;
    checks++; if (bus.forward_sel !== 6'b000101) begin errors++; $display("FAIL b2b_fwd got=%b exp=000101", bus.forward_sel); end
  endtask

  task automatic test_distance2();
    do_reset();
    instr(1, 1, 0, 4'd5, 4'd0, 4'd0, 4'd0, 3'b000); tick();
    instr(1, 1, 0, 4'd6, 4'd0, 4'd0, 4'd0, 3'b000); tick();
    instr(1, 1, 0, 4'd7, 4'd0, 4'd5, 4'd0, 3'b010); tick();
    nop(); #1;
    checks++; if (bus.forward_sel !== 6'b001000) begin errors++; $display("FAIL dist2_wb got=%b exp=001000", bus.forward_sel); end
    do_reset();
    instr(1, 1, 0, 4'd5, 4'd0, 4'd0, 4'd0, 3'b000); tick();
    instr(1, 1, 0, 4'd5, 4'd0, 4'd0, 4'd0, 3'b000); tick();
    instr(1, 1, 0, 4'd7, 4'd0, 4'd5, 4'd0, 3'b010); tick();
    nop(); #1;
    checks++; if (bus.forward_sel !== 6'b000100) begin errors++; $display("FAIL dist2_mem_wins got=%b exp=000100", bus.forward_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    instr(1, 1, 1, 4'd2, 4'd0, 4'd0, 4'd0, 3'b000); tick();
    instr(1, 1, 0, 4'd7, 4'd2, 4'd0, 4'd0, 3'b001); #1;
    checks++; if (obs_ctl() !== 4'b1101) begin errors++; $display("FAIL lu_stall got=%b exp=1101", obs_ctl()); end
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL lu_cnt0 got=%0d exp=0", bus.stall_count); end
    tick();
    checks++; if (obs_ctl() !== 4'b0000) begin errors++; $display("FAIL lu_one_cycle got=%b exp=0000", obs_ctl()); end
    checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL lu_cnt1 got=%0d exp=1", bus.stall_count); end
    tick();
    nop(); #1;
    checks++; if (bus.forward_sel !== 6'b000010) begin errors++; $display("FAIL lu_fwd_wb got=%b exp=000010", bus.forward_sel); end
  endtask

  task automatic test_branch();
    do_reset();
    instr(1, 1, 1, 4'd2, 4'd0, 4'd0, 4'd0, 3'b000); tick();
    instr(1, 1, 0, 4'd7, 4'd2, 4'd0, 4'd0, 3'b001);
    bus.branch_taken_exe = 1; #1;
    checks++; if (obs_ctl() !== 4'b0011) begin errors++; $display("FAIL br_ctl got=%b exp=0011", obs_ctl()); end
    tick();
    bus.branch_taken_exe = 0; nop(); #1;
    checks++; if (bus.flush_count !== 4'd1 || bus.stall_count !== 4'd0) begin
      errors++; $display("FAIL br_cnt got=%0d/%0d exp=1/0", bus.flush_count, bus.stall_count); end
  endtask

  task automatic test_pc_unused();
    do_reset();
    instr(1, 1, 1, 4'd15, 4'd0, 4'd0, 4'd0, 3'b000); tick();
    instr(1, 1, 0, 4'd4, 4'd15, 4'd15, 4'd0, 3'b011); #1;
    checks++; if (obs_ctl() !== 4'b0000) begin errors++; $display("FAIL pc_nostall got=%b exp=0000", obs_ctl()); end
    tick();
    nop(); #1;
    checks++; if (bus.forward_sel !== 6'b000000) begin errors++; $display("FAIL pc_nofwd got=%b exp=000000", bus.forward_sel); end
    do_reset();
    instr(1, 1, 1, 4'd3, 4'd0, 4'd0, 4'd0, 3'b000); tick();
    instr(1, 1, 0, 4'd4, 4'd0, 4'd0, 4'd3, 3'b000); #1;
    checks++; if (obs_ctl() !== 4'b0000) begin errors++; $display("FAIL unused_nostall got=%b exp=0000", obs_ctl()); end
  endtask

  task automatic test_halt();
    do_reset();
    instr(1, 1, 1, 4'd2, 4'd0, 4'd0, 4'd0, 3'b000); tick();
    instr(1, 1, 0, 4'd7, 4'd2, 4'd0, 4'd0, 3'b001);
    bus.halt = 1; #1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (obs_ctl() !== 4'b1100 || bus.stall_count !== 4'd0) begin
        errors++; $display("FAIL halt_hold cyc=%0d got=%b/%0d exp=1100/0", c, obs_ctl(), bus.stall_count); end
      tick();
    end
    bus.halt = 0; #1;
    checks++; if (obs_ctl() !== 4'b1101) begin errors++; $display("FAIL halt_resume got=%b exp=1101", obs_ctl()); end
    tick();
    checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL halt_cnt got=%0d exp=1", bus.stall_count); end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    instr(1, 1, 1, 4'd2, 4'd2, 4'd0, 4'd0, 3'b001);
    for (int c = 0; c < 40; c++) tick();
    checks++; if (bus.stall_count !== 4'd15 || m_stalls != 15) begin
      errors++; $display("FAIL sat_cnt got=%0d model=%0d exp=15", bus.stall_count, m_stalls); end
    tick();
    checks++; if (obs_ctl() !== 4'b1101) begin errors++; $display("FAIL sat_in_stall got=%b exp=1101", obs_ctl()); end
    reset = 1'b1; #1;
    checks++; if (obs_ctl() !== 4'b0000 || bus.forward_sel !== 6'b0 || bus.stall_count !== 4'd0) begin
      errors++; $display("FAIL reset_mid_stall got=%b/%b/%0d exp=0000/000000/0", obs_ctl(), bus.forward_sel, bus.stall_count); end
    clear_model();
    @(posedge clk); #1;
    reset = 1'b0; nop(); #1;
  endtask

  function automatic logic [W-1:0] rnd_reg();
    return ($urandom_range(0, 9) == 0) ? 4'(PC) : 4'($urandom_range(0, 5));
  endfunction

  task automatic test_random();
    bit bad_memload;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.halt             = ($urandom_range(0, 15) == 0);
      bus.branch_taken_exe = ($urandom_range(0, 9) == 0);
      instr($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            rnd_reg(), rnd_reg(), rnd_reg(), rnd_reg(), 3'($urandom_range(0, 7)));
      reset = ($urandom_range(0, 99) == 0);
      #1;
      checks++; if (obs_ctl() !== exp_ctl()) begin
        errors++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", c, obs_ctl(), exp_ctl()); end
      checks++; if (bus.forward_sel !== exp_fwd()) begin
        errors++; $display("FAIL rnd_fwd cyc=%0d got=%b exp=%b", c, bus.forward_sel, exp_fwd()); end
      checks++; if (bus.stall_count !== (reset ? 4'd0 : 4'(m_stalls)) ||
                    bus.flush_count !== (reset ? 4'd0 : 4'(m_flushes))) begin
        errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, bus.stall_count,
                           bus.flush_count, reset ? 0 : m_stalls, reset ? 0 : m_flushes); end
      bad_memload = 0;
      for (int i = 0; i < N; i++)
        if (m_exe.v && m_exe.used[i] && mmatch(m_mem, m_exe.src[i]) && m_mem.ld) bad_memload = 1;
      checks++; if (bad_memload !== 1'b0) begin
        errors++; $display("FAIL rnd_memload_match cyc=%0d got=1 exp=0", c); end
      tick();
      reset = 1'b0;
    end
  endtask

  initial begin
    bus.halt = 0; bus.branch_taken_exe = 0; nop();
    clear_model();
    test_reset();
    test_back_to_back();
    test_distance2();
    test_load_use();
    test_branch();
    test_pc_unused();
    test_halt();
    test_saturation_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipeline (fetch, decode, execute, memory, writeback). It replaces the tied-to-zero forwarding selects with real ones. It keeps its own shadow pipeline of destination and source tags for the EXE, MEM and WB stages, and from that it generates:
- forwarding selects for NUM_SRC operand channels,
- the load-use stall,
- branch flushes,
- halt freeze,
- saturating stall and flush performance counters.

Parameters:
REG_ADDR_W, 4, register address width
NUM_SRC, 3, source operand channels per instruction (A1, A2, Ax/Ay style)
PC_REG, 15, register index that is never forwarded and never hazards
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
halt  in  1  freeze entire pipeline
deco_valid  in  1  decode stage holds a real instruction
deco_src_addr  in  NUM_SRC*REG_ADDR_W  decode source addresses, channel i at [i*REG_ADDR_W +: REG_ADDR_W]
deco_src_used  in  NUM_SRC  channel i actually read
deco_dst_addr  in  REG_ADDR_W  decode destination
deco_reg_write  in  1  decode instruction writes register file
deco_mem_to_reg  in  1  decode instruction is a load
branch_taken_exe  in  1  instruction in EXE redirects PC (conditional unit result)
stall_fetch  out  1  hold PC
stall_deco  out  1  hold IF/DE register
flush_if_de  out  1  IF/DE loads a bubble
flush_deco_exe  out  1  DE/EXE loads a bubble
forward_sel  out  2*NUM_SRC  per channel: 00 regfile, 01 MEM aluResult, 10 WB output, 11 unused
stall_count  out  CNT_W  cycles with load-use stall asserted
flush_count  out  CNT_W  branch flush events

Behaviour:
- Shadow entries EXE, MEM, WB. Each entry holds:
  - valid, dst, reg_write, load,
  - src[NUM_SRC] and used[NUM_SRC] (EXE entry only).
- Reset state:
  - all entries invalid, counters 0;
  - all outputs 0, combinationally, while reset is high.
- Match(e, s): e.valid & e.reg_write & e.dst == s & s != PC_REG.
- load_use (combinational): deco_valid & some used channel i with Match(EXE, src_i) & EXE.load.
- Priority, evaluated each cycle: halt > branch_taken_exe > load_use > normal.
- halt:
  - stall_fetch = stall_deco = 1; flushes 0.
  - Shadow pipeline and counters hold.
  - forward_sel keeps being computed from the held state.
- branch_taken_exe (no halt):
  - flush_if_de = flush_deco_exe = 1; stalls 0; load_use ignored.
  - At the edge: WB<-MEM, MEM<-EXE, EXE<-bubble (valid 0).
  - flush_count += 1, saturating at all-ones.
- load_use (no halt, no branch):
  - stall_fetch = stall_deco = flush_deco_exe = 1; flush_if_de = 0.
  - At the edge: WB<-MEM, MEM<-EXE, EXE<-bubble.
  - stall_count += 1, saturating.
  - Exactly one stall cycle per load-use pair, because the load then sits in MEM and is forwarded from WB one cycle later.
- Normal:
  - Outputs 0 except forward_sel.
  - At the edge: WB<-MEM, MEM<-EXE, EXE<-decode fields, valid = deco_valid.
- forward_sel channel i (combinational from registered state only):
  - If EXE.valid & EXE.used[i] is false, select 00.
  - Else if Match(MEM, EXE.src[i]) & !MEM.load, select 01.
  - Else if Match(WB, EXE.src[i]), select 10.
  - Else 00.
  - MEM is the newest result and beats WB.
  - A MEM load match selects 00. It is unreachable by construction, and the bench asserts it never occurs.
- Destination PC_REG is tracked but never matches.
- A channel with used = 0 never stalls or forwards.
- Reset mid-stall or mid-flush: all state clears immediately and outputs drop in the same cycle.
- Latency: stall and flush are combinational from inputs plus the EXE entry. forward_sel is zero-latency from the registered entries. Counters update at the edge following the event.

Test Plan:
- Back-to-back ALU: r1<-r2+r3, then r4<-r1+r1 (src 1,1, used 11) -> when the second is in EXE, forward_sel[1:0] = forward_sel[3:2] = 01, no stall.
- Distance 2: write r5, independent instruction, read r5 on channel 1 -> forward_sel[3:2] = 10. Same with r5 written in both MEM and WB -> 01.
- Load-use: load r2, next reads r2 on channel 0 -> stall_fetch = stall_deco = flush_deco_exe = 1 for exactly 1 cycle, stall_count 0->1. Next cycle forward_sel[1:0] = 10.
- Branch: branch_taken_exe = 1 while decode holds a load-use consumer -> flush_if_de = flush_deco_exe = 1, stall 0, flush_count 0->1, stall_count unchanged.
- PC_REG / unused / halt:
  - Write r15, then read r15 -> selects 00, no stall.
  - halt for 5 cycles during a load-use -> stalls held, counters unchanged, state resumes identically.
- Saturation and reset:
  - Preload near CNT_W = 4 build, 20 stalls -> stall_count = 15.
  - Assert reset during a stall -> all outputs 0 asynchronously.
